// File: rtl/posit_pkg.sv
// Shared types and constants for the posit SIMD operand decoder.
// Contents: precision codes, field widths, the stage-1 lane record and
//           lane-width / lane-enable lookups.
package posit_pkg;

    localparam int unsigned ES      = 2;   // exponent field width, every lane size
    localparam int unsigned SCALE_W = 8;   // signed per-lane scale width
    localparam int unsigned FRAC_W  = 28;  // per-lane fraction incl. hidden bit
    localparam int unsigned WORD_W  = 32;  // packed operand word width
    localparam int unsigned LANES   = 4;   // max lanes (4 x posit8)
    localparam int unsigned RUN_W   = 6;   // regime run length, up to 31

    typedef enum logic [1:0] {
        PRE_P8  = 2'b00,
        PRE_P16 = 2'b01,
        PRE_P32 = 2'b10,
        PRE_RSV = 2'b11
    } pre_e;

    // Per-lane state held between the two pipeline stages.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              nar;
        logic [RUN_W-1:0]  run;
        logic [WORD_W-1:0] mag;
    } s1_lane_t;

    function automatic int unsigned lane_width(input pre_e pre);
        case (pre)
            PRE_P8:  return 8;
            PRE_P16: return 16;
            PRE_P32: return 32;
            default: return 0;
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_en_of(input pre_e pre);
        case (pre)
            PRE_P8:  return 4'b1111;
            PRE_P16: return 4'b0011;
            PRE_P32: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/posit_lane_decode.sv
// Combinational decode of one posit lane of width W, split at the pipeline
// boundary: the front half (word_i -> sign/zero/nar/mag/run) feeds stage 1,
// the back half (mag_i/run_i -> scale/frac) runs in stage 2 on registered data.
// Ports: word_i raw lane; sign_o/zero_o/nar_o/mag_o/run_o stage-1 results;
//        mag_i/run_i registered stage-1 results; scale_o/frac_o decoded fields.
module posit_lane_decode
    import posit_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]       word_i,
    output logic               sign_o,
    output logic               zero_o,
    output logic               nar_o,
    output logic [W-1:0]       mag_o,
    output logic [RUN_W-1:0]   run_o,
    input  logic [W-1:0]       mag_i,
    input  logic [RUN_W-1:0]   run_i,
    output logic [SCALE_W-1:0] scale_o,
    output logic [FRAC_W-1:0]  frac_o
);

    // Length of the run of identical bits directly below the sign position.
    function automatic logic [RUN_W-1:0] lead_run(input logic [W-1:0] mag);
        logic [RUN_W-1:0] n;
        logic             stop;
        n    = '0;
        stop = 1'b0;
        for (int i = int'(W) - 2; i >= 0; i--) begin
            if (stop || (mag[i] != mag[W-2])) begin
                stop = 1'b1;
            end else begin
                n = n + RUN_W'(1);
            end
        end
        return n;
    endfunction

    // Shift out sign, regime run and terminator; bits past the word end read 0.
    function automatic logic [SCALE_W+FRAC_W-1:0] extract(input logic [W-1:0]     mag,
                                                          input logic [RUN_W-1:0] run);
        logic [W-1:0]        rest;
        logic [W-1:0]        fbits;
        logic [W+FRAC_W-2:0] fwide;
        logic [ES-1:0]       e;
        logic [SCALE_W-1:0]  k;
        logic [SCALE_W-1:0]  scale;
        logic [FRAC_W-1:0]   frac;
        rest  = mag << ((RUN_W+1)'(run) + (RUN_W+1)'(2));
        e     = rest[W-1 -: ES];
        fbits = rest << ES;
        fwide = {fbits, {(FRAC_W-1){1'b0}}};
        frac  = {1'b1, fwide[W+FRAC_W-2 -: FRAC_W-1]};
        k     = mag[W-2] ? (SCALE_W'(run) - SCALE_W'(1)) : (SCALE_W'(0) - SCALE_W'(run));
        scale = (k << ES) + SCALE_W'(e);
        return {scale, frac};
    endfunction

    assign sign_o = word_i[W-1];
    assign zero_o = (word_i == '0);
    assign nar_o  = (word_i == {1'b1, {(W-1){1'b0}}});
    assign mag_o  = word_i[W-1] ? (~word_i + W'(1)) : word_i;
    assign run_o  = lead_run(mag_o);

    assign {scale_o, frac_o} = extract(mag_i, run_i);

endmodule

// File: rtl/posit_simd_decoder.sv
// Two-stage valid/ready operand decoder for packed SIMD posits.
// S1: sign, two's complement and regime run count; S2: field extraction.
// Ports: clk/rst_n; in_valid/in_ready/in_data/in_pre input handshake;
//        out_valid/out_ready plus out_pre, out_lane_en, out_sign, out_zero,
//        out_nar, out_scale, out_frac (lane i at slice i) and out_err.
module posit_simd_decoder
    import posit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_data,
    input  logic [1:0]                 in_pre,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_pre,
    output logic [LANES-1:0]           out_lane_en,
    output logic [LANES-1:0]           out_sign,
    output logic [LANES-1:0]           out_zero,
    output logic [LANES-1:0]           out_nar,
    output logic [LANES*SCALE_W-1:0]   out_scale,
    output logic [LANES*FRAC_W-1:0]    out_frac,
    output logic                       out_err
);

    pre_e     pre_in;
    logic     s1_adv, s2_adv;
    logic     s1_valid_q, s1_valid_d;
    logic     s2_valid_q, s2_valid_d;
    pre_e     s1_pre_q;
    s1_lane_t s1_lane_q [LANES];
    s1_lane_t s1_lane_d [LANES];

    logic [1:0]               pre_q;
    logic [LANES-1:0]         lane_en_q, lane_en_d;
    logic [LANES-1:0]         sign_q, sign_d;
    logic [LANES-1:0]         zero_q, zero_d;
    logic [LANES-1:0]         nar_q, nar_d;
    logic [LANES*SCALE_W-1:0] scale_q, scale_d;
    logic [LANES*FRAC_W-1:0]  frac_q, frac_d;
    logic                     err_q, err_d;

    // Per-instance decoder results for each lane size.
    logic [3:0]         p8_sign, p8_zero, p8_nar;
    logic [7:0]         p8_mag   [4];
    logic [RUN_W-1:0]   p8_run   [4];
    logic [SCALE_W-1:0] p8_scale [4];
    logic [FRAC_W-1:0]  p8_frac  [4];
    logic [1:0]         p16_sign, p16_zero, p16_nar;
    logic [15:0]        p16_mag   [2];
    logic [RUN_W-1:0]   p16_run   [2];
    logic [SCALE_W-1:0] p16_scale [2];
    logic [FRAC_W-1:0]  p16_frac  [2];
    logic               p32_sign, p32_zero, p32_nar;
    logic [31:0]        p32_mag;
    logic [RUN_W-1:0]   p32_run;
    logic [SCALE_W-1:0] p32_scale;
    logic [FRAC_W-1:0]  p32_frac;

    logic [SCALE_W-1:0] sel_scale [LANES];
    logic [FRAC_W-1:0]  sel_frac  [LANES];

    assign pre_in   = pre_e'(in_pre);
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    for (genvar g = 0; g < 4; g++) begin : g_p8
        posit_lane_decode #(.W(8)) u_dec (
            .word_i  (in_data[8*g +: 8]),
            .sign_o  (p8_sign[g]),
            .zero_o  (p8_zero[g]),
            .nar_o   (p8_nar[g]),
            .mag_o   (p8_mag[g]),
            .run_o   (p8_run[g]),
            .mag_i   (s1_lane_q[g].mag[7:0]),
            .run_i   (s1_lane_q[g].run),
            .scale_o (p8_scale[g]),
            .frac_o  (p8_frac[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_p16
        posit_lane_decode #(.W(16)) u_dec (
            .word_i  (in_data[16*g +: 16]),
            .sign_o  (p16_sign[g]),
            .zero_o  (p16_zero[g]),
            .nar_o   (p16_nar[g]),
            .mag_o   (p16_mag[g]),
            .run_o   (p16_run[g]),
            .mag_i   (s1_lane_q[g].mag[15:0]),
            .run_i   (s1_lane_q[g].run),
            .scale_o (p16_scale[g]),
            .frac_o  (p16_frac[g])
        );
    end

    posit_lane_decode #(.W(32)) u_p32 (
        .word_i  (in_data),
        .sign_o  (p32_sign),
        .zero_o  (p32_zero),
        .nar_o   (p32_nar),
        .mag_o   (p32_mag),
        .run_o   (p32_run),
        .mag_i   (s1_lane_q[0].mag),
        .run_i   (s1_lane_q[0].run),
        .scale_o (p32_scale),
        .frac_o  (p32_frac)
    );

    // Stage-1 lane mux on the incoming precision; unused slots stay zero.
    always_comb begin : s1_mux
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        for (int i = 0; i < int'(LANES); i++) begin
            s1_lane_d[i] = '0;
        end
        case (pre_in)
            PRE_P8: begin
                for (int i = 0; i < 4; i++) begin
                    s1_lane_d[i] = '{sign: p8_sign[i], zero: p8_zero[i], nar: p8_nar[i],
                                     run: p8_run[i], mag: WORD_W'(p8_mag[i])};
                end
            end
            PRE_P16: begin
                for (int i = 0; i < 2; i++) begin
                    s1_lane_d[i] = '{sign: p16_sign[i], zero: p16_zero[i], nar: p16_nar[i],
                                     run: p16_run[i], mag: WORD_W'(p16_mag[i])};
                end
            end
            PRE_P32: begin
                s1_lane_d[0] = '{sign: p32_sign, zero: p32_zero, nar: p32_nar,
                                 run: p32_run, mag: p32_mag};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : s1_reg
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pre_q   <= PRE_P8;
            for (int i = 0; i < int'(LANES); i++) begin
                s1_lane_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_adv && in_valid) begin
                s1_pre_q  <= pre_in;
                s1_lane_q <= s1_lane_d;
            end
        end
    end

    // Stage-2 extract mux on the registered precision.
    always_comb begin : s2_mux
        for (int i = 0; i < int'(LANES); i++) begin
            sel_scale[i] = '0;
            sel_frac[i]  = '0;
        end
        case (s1_pre_q)
            PRE_P8: begin
                for (int i = 0; i < 4; i++) begin
                    sel_scale[i] = p8_scale[i];
                    sel_frac[i]  = p8_frac[i];
                end
            end
            PRE_P16: begin
                for (int i = 0; i < 2; i++) begin
                    sel_scale[i] = p16_scale[i];
                    sel_frac[i]  = p16_frac[i];
                end
            end
            PRE_P32: begin
                sel_scale[0] = p32_scale;
                sel_frac[0]  = p32_frac;
            end
            default: ;
        endcase
    end

    // Zero and NaR lanes, and inactive lanes, carry all-zero value fields.
    always_comb begin : s2_fields
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        lane_en_d  = lane_en_of(s1_pre_q);
        err_d      = (s1_pre_q == PRE_RSV);
        sign_d     = '0;
        zero_d     = '0;
        nar_d      = '0;
        scale_d    = '0;
        frac_d     = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            zero_d[i] = lane_en_d[i] && s1_lane_q[i].zero;
            nar_d[i]  = lane_en_d[i] && s1_lane_q[i].nar;
            if (lane_en_d[i] && !s1_lane_q[i].zero && !s1_lane_q[i].nar) begin
                sign_d[i]                      = s1_lane_q[i].sign;
                scale_d[i*SCALE_W +: SCALE_W]  = sel_scale[i];
                frac_d[i*FRAC_W +: FRAC_W]     = sel_frac[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : s2_reg
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            pre_q      <= 2'b00;
            lane_en_q  <= '0;
            sign_q     <= '0;
            zero_q     <= '0;
            nar_q      <= '0;
            scale_q    <= '0;
            frac_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_adv && s1_valid_q) begin
                pre_q     <= s1_pre_q;
                lane_en_q <= lane_en_d;
                sign_q    <= sign_d;
                zero_q    <= zero_d;
                nar_q     <= nar_d;
                scale_q   <= scale_d;
                frac_q    <= frac_d;
                err_q     <= err_d;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_pre     = pre_q;
    assign out_lane_en = lane_en_q;
    assign out_sign    = sign_q;
    assign out_zero    = zero_q;
    assign out_nar     = nar_q;
    assign out_scale   = scale_q;
    assign out_frac    = frac_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_posit_simd_decoder.sv
// Directed self-checking bench for posit_simd_decoder: per-precision decode
// vectors with hand-computed fields, backpressure ordering, async reset
// mid-flight and the reserved precision code.
module tb_posit_simd_decoder;
    import posit_pkg::*;

    localparam logic [27:0] F1 = 28'h8000000;  // hidden bit only

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [1:0]   in_pre;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_pre;
    logic [3:0]   out_lane_en;
    logic [3:0]   out_sign;
    logic [3:0]   out_zero;
    logic [3:0]   out_nar;
    logic [31:0]  out_scale;
    logic [111:0] out_frac;
    logic         out_err;

    int n_checks = 0;
    int n_fail   = 0;

    posit_simd_decoder u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_pre      (in_pre),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pre     (out_pre),
        .out_lane_en (out_lane_en),
        .out_sign    (out_sign),
        .out_zero    (out_zero),
        .out_nar     (out_nar),
        .out_scale   (out_scale),
        .out_frac    (out_frac),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word, confirm 2-cycle latency; leaves outputs valid for checking.
    task automatic decode_one(input string tag, input logic [1:0] pre, input logic [31:0] data);
        in_pre   = pre;
        in_data  = data;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".lat1"}, 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        check({tag, ".lat2"}, 128'(out_valid), 128'(1'b1));
        check({tag, ".pre"}, 128'(out_pre), 128'(pre));
    endtask

    task automatic check_word(input string tag, input logic [3:0] en, input logic [3:0] sg,
                              input logic [3:0] zr, input logic [3:0] nr,
                              input logic [31:0] sc, input logic [111:0] fr, input logic er);
        check({tag, ".lane_en"}, 128'(out_lane_en), 128'(en));
        check({tag, ".sign"},    128'(out_sign),    128'(sg));
        check({tag, ".zero"},    128'(out_zero),    128'(zr));
        check({tag, ".nar"},     128'(out_nar),     128'(nr));
        check({tag, ".scale"},   128'(out_scale),   128'(sc));
        check({tag, ".frac"},    128'(out_frac),    128'(fr));
        check({tag, ".err"},     128'(out_err),     128'(er));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] bp [4];
    int          sent, got, cyc;
    logic        hs_in, hs_out;
    logic [7:0]  obs;

    initial begin
        bp[0] = 32'h40000000;  // scale 0
        bp[1] = 32'h48000000;  // scale 1
        bp[2] = 32'h50000000;  // scale 2
        bp[3] = 32'h58000000;  // scale 3

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pre    = 2'b00;
        out_ready = 1'b1;
        #12;
        check("rst.out_valid", 128'(out_valid), 128'(1'b0));
        check("rst.in_ready",  128'(in_ready),  128'(1'b1));
        check("rst.out_pre",   128'(out_pre),   128'(2'b00));
        check("rst.scale",     128'(out_scale), 128'(32'h0));
        check("rst.frac",      128'(out_frac),  128'(112'h0));
        check("rst.err",       128'(out_err),   128'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        decode_one("p32_one", 2'b10, 32'h40000000);
        check_word("p32_one", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0, {84'h0, F1}, 1'b0);

        decode_one("p32_nar", 2'b10, 32'h80000000);
        check_word("p32_nar", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 32'h0, 112'h0, 1'b0);

        decode_one("p32_zero", 2'b10, 32'h00000000);
        check_word("p32_zero", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0, 112'h0, 1'b0);

        decode_one("p8_mix", 2'b00, 32'h7FC04840);
        check_word("p8_mix", 4'b1111, 4'b0100, 4'b0000, 4'b0000, 32'h18000100,
                   {F1, F1, F1, F1}, 1'b0);

        // lanes: 0xC0 neg one, 0x80 NaR, 0x4B scale 1 frac 1.011b, 0x00 zero
        decode_one("p8_spec", 2'b00, 32'h004B80C0);
        check_word("p8_spec", 4'b1111, 4'b0001, 4'b1000, 4'b0010, 32'h00010000,
                   {28'h0, 28'hB000000, 28'h0, F1}, 1'b0);

        decode_one("p16_trunc", 2'b01, 32'h00015000);
        check_word("p16_trunc", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 32'h0000C802,
                   {56'h0, F1, F1}, 1'b0);

        decode_one("p16_neg", 2'b01, 32'hFFFF8000);
        check_word("p16_neg", 4'b0011, 4'b0010, 4'b0000, 4'b0001, 32'h0000C800,
                   {56'h0, F1, 28'h0}, 1'b0);

        decode_one("p32_max", 2'b10, 32'h7FFFFFFF);
        check_word("p32_max", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h00000078, {84'h0, F1}, 1'b0);

        decode_one("p32_min", 2'b10, 32'h00000001);
        check_word("p32_min", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h00000088, {84'h0, F1}, 1'b0);

        // magnitude 0x3FFFFFFF: k=-1, e=3, full 27-bit fraction of ones
        decode_one("p32_fneg", 2'b10, 32'hC0000001);
        check_word("p32_fneg", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h000000FF,
                   {84'h0, 28'hFFFFFFF}, 1'b0);

        decode_one("rsv", 2'b11, 32'h12345678);
        check_word("rsv", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 112'h0, 1'b1);

        // Backpressure: two words fill the pipe, then in_ready drops.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_pre    = 2'b10;
        in_valid  = 1'b1;
        in_data   = bp[0];
        check("bp.rdy0", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_data = bp[1];
        check("bp.rdy1", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_data = bp[2];
        check("bp.stall",   128'(in_ready),        128'(1'b0));
        check("bp.hold_v",  128'(out_valid),       128'(1'b1));
        check("bp.hold_s0", 128'(out_scale[7:0]),  128'(8'd0));
        @(posedge clk); #1;
        check("bp.stall2",  128'(in_ready),        128'(1'b0));
        check("bp.hold_v2", 128'(out_valid),       128'(1'b1));
        check("bp.hold_s1", 128'(out_scale[7:0]),  128'(8'd0));
        out_ready = 1'b1;
        #1;
        check("bp.rdy_comb", 128'(in_ready), 128'(1'b1));
        sent = 2;
        got  = 0;
        cyc  = 0;
        while (got < 4 && cyc < 20) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            obs    = out_scale[7:0];
            @(posedge clk); #1;
            cyc++;
            if (hs_out) begin
                check($sformatf("bp.order%0d", got), 128'(obs), 128'(got));
                got++;
            end
            if (hs_in) begin
                sent++;
                if (sent < 4) in_data = bp[sent];
                else          in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp.count",   128'(got),       128'(4));
        check("bp.cycles",  128'(cyc),       128'(4));
        check("bp.drained", 128'(out_valid), 128'(1'b0));

        // Reset pulse between edges with both stages full.
        out_ready = 1'b0;
        in_pre    = 2'b10;
        in_valid  = 1'b1;
        in_data   = 32'h40000000;
        @(posedge clk); #1;
        in_data = 32'h48000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid.pre_v",   128'(out_valid), 128'(1'b1));
        check("rst_mid.pre_rdy", 128'(in_ready),  128'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.async_v",   128'(out_valid), 128'(1'b0));
        check("rst_mid.async_rdy", 128'(in_ready),  128'(1'b1));
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid.quiet%0d", i), 128'(out_valid), 128'(1'b0));
        end
        check("rst_mid.rdy", 128'(in_ready), 128'(1'b1));

        decode_one("post_rst", 2'b01, 32'h00015000);
        check_word("post_rst", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 32'h0000C802,
                   {56'h0, F1, F1}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
